// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronises the CC_PLL lock flags, holds per-domain resets until lock is
// stable, releases them in staggered order, and restarts the steady-lock flag on loss or timeout.
//
// state     | meaning
// WAIT_LOCK | waiting for lock_s, timeout counter running
// STRETCH   | lock_s high, qualifying for STRETCH_CYCLES
// RELEASE   | deasserting rst_out[i] every STAGGER_CYCLES
// RUN       | all resets released, locked=1
// RESTART   | stdy_rst pulse, rst_out held high
module pll_lock_supervisor #(
  parameter int NUM_RST        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 1000,
  parameter int RESTART_CYCLES = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 pll_locked,
  input  logic                 pll_locked_stdy,
  input  logic                 clear_err,
  output logic                 stdy_rst,
  output logic [NUM_RST-1:0]   rst_out,
  output logic                 locked,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] loss_count,
  output logic                 timeout_err
);

  localparam int REL_LAST = (NUM_RST - 1) * STAGGER_CYCLES;
  localparam int MAX_A    = (LOCK_TIMEOUT > STRETCH_CYCLES) ? LOCK_TIMEOUT : STRETCH_CYCLES;
  localparam int MAX_B    = (RESTART_CYCLES > REL_LAST + 1) ? RESTART_CYCLES : REL_LAST + 1;
  localparam int MAX_C    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW       = $clog2(MAX_C) + 1;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STRETCH   = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    RESTART   = 3'd4
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] stdy_sync;
  logic [TW-1:0]          cnt;
  logic [TW-1:0]          cnt_inc;
  logic                   lock_s;
  logic                   stdy_s;
  logic                   loss_evt;

  assign lock_s   = lock_sync[SYNC_STAGES-1];
  assign stdy_s   = stdy_sync[SYNC_STAGES-1];
  assign cnt_inc  = cnt + TW'(1);
  assign loss_evt = !lock_s || !stdy_s;
  assign state    = state_q;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      lock_sync   <= '0;
      stdy_sync   <= '0;
      cnt         <= '0;
      rst_out     <= '1;
      locked      <= 1'b0;
      stdy_rst    <= 1'b0;
      loss_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
      stdy_sync <= {stdy_sync[SYNC_STAGES-2:0], pll_locked_stdy};

      // Set/increment events below override this clear when they coincide.
      if (clear_err) begin
        loss_count  <= '0;
        timeout_err <= 1'b0;
      end

      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= STRETCH;
            cnt     <= '0;
          end else if (cnt == TW'(LOCK_TIMEOUT - 1)) begin
            state_q     <= RESTART;
            cnt         <= '0;
            stdy_rst    <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        STRETCH: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt     <= '0;
          end else if (cnt == TW'(STRETCH_CYCLES - 1)) begin
            state_q    <= RELEASE;
            cnt        <= '0;
            rst_out[0] <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        RELEASE, RUN: begin
          if (loss_evt) begin
            state_q    <= RESTART;
            cnt        <= '0;
            rst_out    <= '1;
            locked     <= 1'b0;
            stdy_rst   <= 1'b1;
            loss_count <= clear_err ? CNT_WIDTH'(1) :
                          (&loss_count) ? loss_count : loss_count + CNT_WIDTH'(1);
          end else if (state_q == RELEASE) begin
            if (cnt == TW'(REL_LAST)) begin
              state_q <= RUN;
              cnt     <= '0;
              locked  <= 1'b1;
            end else begin
              cnt <= cnt_inc;
              for (int i = 1; i < NUM_RST; i++) begin
                if (int'(cnt_inc) == i * STAGGER_CYCLES) rst_out[i] <= 1'b0;
              end
            end
          end
        end

        RESTART: begin
          if (cnt == TW'(RESTART_CYCLES - 1)) begin
            state_q  <= WAIT_LOCK;
            cnt      <= '0;
            stdy_rst <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state_q  <= WAIT_LOCK;
          cnt      <= '0;
          rst_out  <= '1;
          locked   <= 1'b0;
          stdy_rst <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: default instance (a) and a NUM_RST=1, CNT_WIDTH=2
// instance (b). Cycle k is the interval after clock edge k; cycle 0 follows the last reset edge.
module tb_pll_lock_supervisor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, a_lock, a_stdy, a_clr;
  logic       a_stdy_rst, a_locked, a_terr;
  logic [3:0] a_rst_out;
  logic [2:0] a_state;
  logic [7:0] a_loss;

  logic       b_reset, b_lock, b_stdy, b_clr;
  logic       b_stdy_rst, b_locked, b_terr;
  logic [0:0] b_rst_out;
  logic [2:0] b_state;
  logic [1:0] b_loss;

  int cyc;
  int checks;
  int errors;

  pll_lock_supervisor dut_a (
    .clock_in       (clk),
    .reset          (a_reset),
    .pll_locked     (a_lock),
    .pll_locked_stdy(a_stdy),
    .clear_err      (a_clr),
    .stdy_rst       (a_stdy_rst),
    .rst_out        (a_rst_out),
    .locked         (a_locked),
    .state          (a_state),
    .loss_count     (a_loss),
    .timeout_err    (a_terr)
  );

  pll_lock_supervisor #(.NUM_RST(1), .CNT_WIDTH(2)) dut_b (
    .clock_in       (clk),
    .reset          (b_reset),
    .pll_locked     (b_lock),
    .pll_locked_stdy(b_stdy),
    .clear_err      (b_clr),
    .stdy_rst       (b_stdy_rst),
    .rst_out        (b_rst_out),
    .locked         (b_locked),
    .state          (b_state),
    .loss_count     (b_loss),
    .timeout_err    (b_terr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_a(input string tag, input logic [2:0] st, input logic [3:0] rs,
                       input logic lk, input logic sr, input logic [7:0] lc, input logic te);
    check({tag, ".state"},       32'(a_state),    32'(st));
    check({tag, ".rst_out"},     32'(a_rst_out),  32'(rs));
    check({tag, ".locked"},      32'(a_locked),   32'(lk));
    check({tag, ".stdy_rst"},    32'(a_stdy_rst), 32'(sr));
    check({tag, ".loss_count"},  32'(a_loss),     32'(lc));
    check({tag, ".timeout_err"}, 32'(a_terr),     32'(te));
  endtask

  task automatic chk_b(input string tag, input logic [2:0] st, input logic rs,
                       input logic lk, input logic sr, input logic [1:0] lc);
    check({tag, ".state"},      32'(b_state),    32'(st));
    check({tag, ".rst_out"},    32'(b_rst_out),  32'(rs));
    check({tag, ".locked"},     32'(b_locked),   32'(lk));
    check({tag, ".stdy_rst"},   32'(b_stdy_rst), 32'(sr));
    check({tag, ".loss_count"}, 32'(b_loss),     32'(lc));
  endtask

  initial begin
    int t;
    cyc    = 0;
    checks = 0;
    errors = 0;
    a_reset = 1'b1; a_lock = 1'b0; a_stdy = 1'b0; a_clr = 1'b0;
    b_reset = 1'b1; b_lock = 1'b0; b_stdy = 1'b0; b_clr = 1'b0;
    repeat (3) tick();
    a_reset = 1'b0;
    cyc = 0;
    chk_a("reset", 3'd0, 4'hF, 1'b0, 1'b0, 8'd0, 1'b0);

    // Normal lock
    goto(10); a_lock = 1'b1; a_stdy = 1'b1;
    goto(12); chk_a("wait_sync",  3'd0, 4'hF, 1'b0, 1'b0, 8'd0, 1'b0);
    goto(13); chk_a("stretch_in", 3'd1, 4'hF, 1'b0, 1'b0, 8'd0, 1'b0);
    goto(28); chk_a("stretch_end",3'd1, 4'hF, 1'b0, 1'b0, 8'd0, 1'b0);
    goto(29); chk_a("rel0",       3'd2, 4'hE, 1'b0, 1'b0, 8'd0, 1'b0);
    goto(32); chk_a("rel0_hold",  3'd2, 4'hE, 1'b0, 1'b0, 8'd0, 1'b0);
    goto(33); chk_a("rel1",       3'd2, 4'hC, 1'b0, 1'b0, 8'd0, 1'b0);
    goto(37); chk_a("rel2",       3'd2, 4'h8, 1'b0, 1'b0, 8'd0, 1'b0);
    goto(41); chk_a("rel3",       3'd2, 4'h0, 1'b0, 1'b0, 8'd0, 1'b0);
    goto(42); chk_a("run",        3'd3, 4'h0, 1'b1, 1'b0, 8'd0, 1'b0);

    // Lock loss in RUN
    goto(50); a_lock = 1'b0;
    goto(52); chk_a("loss_pre",   3'd3, 4'h0, 1'b1, 1'b0, 8'd0, 1'b0);
    goto(53); chk_a("loss",       3'd4, 4'hF, 1'b0, 1'b1, 8'd1, 1'b0);
    goto(56); chk_a("restart_end",3'd4, 4'hF, 1'b0, 1'b1, 8'd1, 1'b0);
    goto(57); chk_a("rewait",     3'd0, 4'hF, 1'b0, 1'b0, 8'd1, 1'b0);
    goto(60); a_lock = 1'b1;
    goto(63); chk_a("relock",     3'd1, 4'hF, 1'b0, 1'b0, 8'd1, 1'b0);

    // Glitch 8 cycles into STRETCH
    goto(71); a_lock = 1'b0;
    goto(74); a_lock = 1'b1;
    chk_a("glitch_wait", 3'd0, 4'hF, 1'b0, 1'b0, 8'd1, 1'b0);
    goto(76); chk_a("glitch_sync", 3'd0, 4'hF, 1'b0, 1'b0, 8'd1, 1'b0);
    goto(77); chk_a("glitch_str",  3'd1, 4'hF, 1'b0, 1'b0, 8'd1, 1'b0);
    goto(92); chk_a("glitch_full", 3'd1, 4'hF, 1'b0, 1'b0, 8'd1, 1'b0);
    goto(93); chk_a("glitch_rel",  3'd2, 4'hE, 1'b0, 1'b0, 8'd1, 1'b0);
    goto(106); chk_a("glitch_run", 3'd3, 4'h0, 1'b1, 1'b0, 8'd1, 1'b0);

    // Steady-flag loss in RUN, then stdy ignored in WAIT_LOCK/STRETCH, loss in RELEASE
    goto(110); a_stdy = 1'b0;
    goto(112); chk_a("sloss_pre", 3'd3, 4'h0, 1'b1, 1'b0, 8'd1, 1'b0);
    goto(113); chk_a("sloss",     3'd4, 4'hF, 1'b0, 1'b1, 8'd2, 1'b0);
    goto(117); chk_a("sloss_wait",3'd0, 4'hF, 1'b0, 1'b0, 8'd2, 1'b0);
    goto(118); chk_a("stdy_ign",  3'd1, 4'hF, 1'b0, 1'b0, 8'd2, 1'b0);
    goto(134); chk_a("rel_stdy0", 3'd2, 4'hE, 1'b0, 1'b0, 8'd2, 1'b0);
    goto(135); chk_a("rel_loss",  3'd4, 4'hF, 1'b0, 1'b1, 8'd3, 1'b0);
    goto(136); a_stdy = 1'b1;
    goto(139); chk_a("rel_rewait",3'd0, 4'hF, 1'b0, 1'b0, 8'd3, 1'b0);
    goto(140); a_clr = 1'b1;
    chk_a("clr_pre", 3'd1, 4'hF, 1'b0, 1'b0, 8'd3, 1'b0);
    goto(141); a_clr = 1'b0;
    chk_a("clr_loss", 3'd1, 4'hF, 1'b0, 1'b0, 8'd0, 1'b0);

    // Reset mid-RELEASE
    goto(156); chk_a("mid_rel0", 3'd2, 4'hE, 1'b0, 1'b0, 8'd0, 1'b0);
    goto(160); chk_a("mid_rel1", 3'd2, 4'hC, 1'b0, 1'b0, 8'd0, 1'b0);
    a_reset = 1'b1; a_lock = 1'b0; a_stdy = 1'b0;
    goto(161); chk_a("rst_mid_rel", 3'd0, 4'hF, 1'b0, 1'b0, 8'd0, 1'b0);
    a_reset = 1'b0;
    cyc = 0;

    // Timeout with the PLL never locking
    goto(999);  chk_a("to_pre",   3'd0, 4'hF, 1'b0, 1'b0, 8'd0, 1'b0);
    goto(1000); chk_a("to",       3'd4, 4'hF, 1'b0, 1'b1, 8'd0, 1'b1);
    goto(1003); chk_a("to_pulse", 3'd4, 4'hF, 1'b0, 1'b1, 8'd0, 1'b1);
    goto(1004); chk_a("to_wait",  3'd0, 4'hF, 1'b0, 1'b0, 8'd0, 1'b1);
    goto(2003); chk_a("to2_pre",  3'd0, 4'hF, 1'b0, 1'b0, 8'd0, 1'b1);
    goto(2004); chk_a("to2",      3'd4, 4'hF, 1'b0, 1'b1, 8'd0, 1'b1);
    a_clr = 1'b1;
    goto(2005); a_clr = 1'b0;
    chk_a("to_clr", 3'd4, 4'hF, 1'b0, 1'b1, 8'd0, 1'b0);
    a_reset = 1'b1;
    goto(2006); chk_a("rst_mid_restart", 3'd0, 4'hF, 1'b0, 1'b0, 8'd0, 1'b0);
    a_reset = 1'b0;
    cyc = 0;
    goto(999); a_clr = 1'b1;
    goto(1000); a_clr = 1'b0;
    chk_a("to_vs_clr", 3'd4, 4'hF, 1'b0, 1'b1, 8'd0, 1'b1);

    // Instance b: NUM_RST=1, CNT_WIDTH=2
    b_reset = 1'b0;
    cyc = 0;
    chk_b("b_reset", 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    goto(10); b_lock = 1'b1; b_stdy = 1'b1;
    goto(28); chk_b("b_stretch", 3'd1, 1'b1, 1'b0, 1'b0, 2'd0);
    goto(29); chk_b("b_rel",     3'd2, 1'b0, 1'b0, 1'b0, 2'd0);
    goto(30); chk_b("b_run",     3'd3, 1'b0, 1'b1, 1'b0, 2'd0);

    for (int k = 1; k <= 5; k++) begin
      t = cyc;
      b_lock = 1'b0;
      goto(t + 2);  chk_b("b_sat_pre",  3'd3, 1'b0, 1'b1, 1'b0, 2'(k - 1 > 3 ? 3 : k - 1));
      goto(t + 3);  chk_b("b_sat_loss", 3'd4, 1'b1, 1'b0, 1'b1, 2'(k > 3 ? 3 : k));
      goto(t + 7);  chk_b("b_sat_wait", 3'd0, 1'b1, 1'b0, 1'b0, 2'(k > 3 ? 3 : k));
      b_lock = 1'b1;
      goto(t + 27); chk_b("b_sat_run",  3'd3, 1'b0, 1'b1, 1'b0, 2'(k > 3 ? 3 : k));
    end

    t = cyc;
    b_lock = 1'b0;
    goto(t + 2); b_clr = 1'b1;
    goto(t + 3); b_clr = 1'b0;
    chk_b("b_clr_vs_loss", 3'd4, 1'b1, 1'b0, 1'b1, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
